// File: rtl/i2c_wr_arbiter_if.sv
// Bus bundle between the two write requesters, the arbiter and the I2C master.
// The master modport is the arbiter's view; the slave modport is the far side.
interface i2c_wr_arbiter_if;
    logic        req0;
    logic [15:0] data0;
    logic        ack0;
    logic        done0;
    logic        req1;
    logic [15:0] data1;
    logic        ack1;
    logic        done1;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    modport master (
        input  req0, data0, req1, data1, i2c_done, err_clr,
        output ack0, done0, ack1, done1, i2c_exec, i2c_data,
        output busy, timeout_err
    );

    modport slave (
        output req0, data0, req1, data1, i2c_done, err_clr,
        input  ack0, done0, ack1, done1, i2c_exec, i2c_data,
        input  busy, timeout_err
    );
endinterface

// File: rtl/i2c_wr_arbiter.sv
// Two-port arbiter in front of a single I2C write master, with a
// completion watchdog and a sticky timeout flag.
module i2c_wr_arbiter #(
    parameter logic [15:0] TO_CYC = 16'd5000,
    parameter logic        FAIR   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    i2c_wr_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] data_q, data_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        exec_q, exec_d;
    logic        err_q, err_d;
    logic        win;

    // Round-robin favours the port that was not granted last time.
    always_comb begin
        win = 1'b0;
        if (FAIR) begin
            if (bus.req0 && bus.req1) win = ~last_q;
            else                      win = bus.req1;
        end else begin
            win = ~bus.req0;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        tmr_d   = tmr_q;
        data_d  = data_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        exec_d  = 1'b0;
        err_d   = err_q & ~bus.err_clr;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    data_d  = win ? bus.data1 : bus.data0;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    gnt_d   = win;
                    last_d  = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                exec_d  = 1'b1;
                tmr_d   = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                tmr_d = tmr_q + 16'd1;
                // A completion coinciding with expiry is a success.
                if (bus.i2c_done) begin
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    state_d = IDLE;
                end else if (tmr_q == TO_CYC - 16'd1) begin
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            tmr_q   <= 16'd0;
            data_q  <= 16'd0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            exec_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;
            data_q  <= data_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            exec_q  <= exec_d;
            err_q   <= err_d;
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.i2c_exec    = exec_q;
    assign bus.i2c_data    = data_q;
    assign bus.timeout_err = err_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_wr_arbiter.sv
// Bench for i2c_wr_arbiter: fixed-priority, round-robin and short-timeout
// instances, with a scoreboard of expected {port, word} grants.
module tb_i2c_wr_arbiter;

    localparam int LAT = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_wr_arbiter_if bf ();
    i2c_wr_arbiter_if br ();
    i2c_wr_arbiter_if bt ();

    i2c_wr_arbiter #(.TO_CYC(16'd5000), .FAIR(1'b0)) u_fp (
        .clk(clk), .rst(rst), .bus(bf)
    );
    i2c_wr_arbiter #(.TO_CYC(16'd5000), .FAIR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .bus(br)
    );
    i2c_wr_arbiter #(.TO_CYC(16'd8), .FAIR(1'b0)) u_to (
        .clk(clk), .rst(rst), .bus(bt)
    );

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    // I2C master models: i2c_done LAT cycles after the exec cycle.
    int cnt_f = 0;
    int cnt_r = 0;
    always @(negedge clk) begin
        if (cnt_f != 0) begin
            cnt_f <= cnt_f - 1;
            bf.i2c_done <= (cnt_f == 1);
        end else begin
            bf.i2c_done <= 1'b0;
            if (bf.i2c_exec === 1'b1) cnt_f <= LAT;
        end
    end
    always @(negedge clk) begin
        if (cnt_r != 0) begin
            cnt_r <= cnt_r - 1;
            br.i2c_done <= (cnt_r == 1);
        end else begin
            br.i2c_done <= 1'b0;
            if (br.i2c_exec === 1'b1) cnt_r <= LAT;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bf.ack0, bf.ack1, bf.done0, bf.done1, bf.i2c_exec,
             bf.i2c_data, bf.busy, bf.timeout_err} !== 23'd0) begin
            errors++;
            $display("FAIL reset_fp: got data %h busy %b want 0",
                     bf.i2c_data, bf.busy);
        end
        checks++;
        if ({br.ack0, br.ack1, br.done0, br.done1, br.i2c_exec,
             br.i2c_data, br.busy, br.timeout_err} !== 23'd0) begin
            errors++;
            $display("FAIL reset_rr: got data %h busy %b want 0",
                     br.i2c_data, br.busy);
        end
        checks++;
        if ({bt.ack0, bt.ack1, bt.done0, bt.done1, bt.i2c_exec,
             bt.i2c_data, bt.busy, bt.timeout_err} !== 23'd0) begin
            errors++;
            $display("FAIL reset_to: got data %h busy %b want 0",
                     bt.i2c_data, bt.busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int k = 0;
        bit seen = 0;
        bit stray = 0;
        logic [16:0] e;
        bf.data0 = 16'h0E0F;
        bf.req0  = 1'b1;
        exp_q.push_back({1'b0, 16'h0E0F});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({bf.ack0, bf.ack1} !== {~e[16], e[16]}) begin
            errors++;
            $display("FAIL single_ack: got %b%b want %b%b",
                     bf.ack0, bf.ack1, ~e[16], e[16]);
        end
        checks++;
        if (bf.i2c_data !== e[15:0]) begin
            errors++;
            $display("FAIL single_data: got %h want %h", bf.i2c_data, e[15:0]);
        end
        bf.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bf.i2c_exec, bf.ack0} !== 2'b10) begin
            errors++;
            $display("FAIL single_exec: got %b want 10", {bf.i2c_exec, bf.ack0});
        end
        while (k < 200 && !seen) begin
            @(negedge clk);
            k++;
            stray = stray | bf.ack1 | bf.done1 | bf.i2c_exec;
            if (bf.done0) seen = 1;
        end
        checks++;
        if (k !== LAT + 1) begin
            errors++;
            $display("FAIL single_done_lat: got %0d want %0d", k, LAT + 1);
        end
        checks++;
        if (bf.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b want 0", bf.busy);
        end
        @(negedge clk);
        checks++;
        if (bf.done0 !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width: got %b want 0", bf.done0);
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL single_stray: got %b want 0", stray);
        end
    endtask

    task automatic test_fixed_prio;
        logic [15:0] d0 [3];
        logic [15:0] d1 [3];
        logic [16:0] e;
        int n0 = 0, n1 = 0, got = 0, k = 0;
        bit p0 = 0, p1 = 0;
        d0[0] = 16'h1001; d0[1] = 16'h1002; d0[2] = 16'h1003;
        d1[0] = 16'h2001; d1[1] = 16'h2002; d1[2] = 16'h2003;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, d0[i]});
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, d1[i]});
        bf.data0 = d0[0]; bf.req0 = 1'b1;
        bf.data1 = d1[0]; bf.req1 = 1'b1;
        while (got < 6 && k < 2000) begin
            @(negedge clk);
            k++;
            if (p0) begin bf.data0 = d0[n0]; bf.req0 = 1'b1; p0 = 0; end
            if (p1) begin bf.data1 = d1[n1]; bf.req1 = 1'b1; p1 = 0; end
            if (bf.ack0 || bf.ack1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fp_extra: got grant %0d want none", got);
                end else begin
                    e = exp_q.pop_front();
                    if ({bf.ack1, bf.ack0} !== {e[16], ~e[16]} ||
                        bf.i2c_data !== e[15:0]) begin
                        errors++;
                        $display("FAIL fp_order: got port %b data %h want port %b data %h",
                                 bf.ack1, bf.i2c_data, e[16], e[15:0]);
                    end
                end
                if (bf.ack0) begin bf.req0 = 1'b0; n0++; p0 = (n0 < 3); end
                if (bf.ack1) begin bf.req1 = 1'b0; n1++; p1 = (n1 < 3); end
            end
        end
        checks++;
        if (got !== 6) begin
            errors++;
            $display("FAIL fp_count: got %0d want 6", got);
        end
        k = 0;
        while (bf.busy && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (bf.busy !== 1'b0) begin
            errors++;
            $display("FAIL fp_idle: got %b want 0", bf.busy);
        end
    endtask

    task automatic test_round_robin;
        logic [15:0] d0 [3];
        logic [15:0] d1 [3];
        logic [16:0] e;
        int n0 = 0, n1 = 0, got = 0, k = 0;
        bit p0 = 0, p1 = 0;
        d0[0] = 16'h3001; d0[1] = 16'h3002; d0[2] = 16'h3003;
        d1[0] = 16'h4001; d1[1] = 16'h4002; d1[2] = 16'h4003;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, d0[i]});
            exp_q.push_back({1'b1, d1[i]});
        end
        br.data0 = d0[0]; br.req0 = 1'b1;
        br.data1 = d1[0]; br.req1 = 1'b1;
        while (got < 6 && k < 2000) begin
            @(negedge clk);
            k++;
            if (p0) begin br.data0 = d0[n0]; br.req0 = 1'b1; p0 = 0; end
            if (p1) begin br.data1 = d1[n1]; br.req1 = 1'b1; p1 = 0; end
            if (br.ack0 || br.ack1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_extra: got grant %0d want none", got);
                end else begin
                    e = exp_q.pop_front();
                    if ({br.ack1, br.ack0} !== {e[16], ~e[16]} ||
                        br.i2c_data !== e[15:0]) begin
                        errors++;
                        $display("FAIL rr_order: got port %b data %h want port %b data %h",
                                 br.ack1, br.i2c_data, e[16], e[15:0]);
                    end
                end
                if (br.ack0) begin br.req0 = 1'b0; n0++; p0 = (n0 < 3); end
                if (br.ack1) begin br.req1 = 1'b0; n1++; p1 = (n1 < 3); end
            end
        end
        checks++;
        if (got !== 6) begin
            errors++;
            $display("FAIL rr_count: got %0d want 6", got);
        end
        k = 0;
        while (br.busy && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (br.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got %b want 0", br.busy);
        end
    endtask

    // Drives one request on the timeout instance; returns at its exec cycle.
    task automatic issue_bt(input bit port, input logic [15:0] d,
                            output bit ok);
        int k = 0;
        exp_q.push_back({port, d});
        if (port) begin bt.data1 = d; bt.req1 = 1'b1; end
        else      begin bt.data0 = d; bt.req0 = 1'b1; end
        do begin
            @(negedge clk);
            k++;
        end while (!(port ? bt.ack1 : bt.ack0) && k < 20);
        bt.req0 = 1'b0;
        bt.req1 = 1'b0;
        @(negedge clk);
        ok = (bt.i2c_exec === 1'b1);
    endtask

    task automatic test_timeout;
        bit ok;
        bit early = 0;
        int k = 0;
        logic [16:0] e;
        issue_bt(1'b0, 16'h1234, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bt.i2c_data !== e[15:0]) begin
            errors++;
            $display("FAIL to_issue: got exec %b data %h want 1 %h",
                     ok, bt.i2c_data, e[15:0]);
        end
        while (!bt.done0 && k < 50) begin
            @(negedge clk);
            k++;
            if (!bt.done0 && bt.timeout_err) early = 1;
        end
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL to_latency: got %0d want 8", k);
        end
        checks++;
        if ({bt.timeout_err, early, bt.done1} !== 3'b100) begin
            errors++;
            $display("FAIL to_flag: got %b want 100",
                     {bt.timeout_err, early, bt.done1});
        end
        bt.err_clr = 1'b1;
        @(negedge clk);
        bt.err_clr = 1'b0;
        checks++;
        if (bt.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: got %b want 0", bt.timeout_err);
        end
        issue_bt(1'b1, 16'h5678, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bt.i2c_data !== e[15:0]) begin
            errors++;
            $display("FAIL to_issue2: got exec %b data %h want 1 %h",
                     ok, bt.i2c_data, e[15:0]);
        end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 7) bt.err_clr = 1'b1;
            if (j == 8) bt.err_clr = 1'b0;
        end
        checks++;
        if ({bt.done1, bt.done0, bt.timeout_err} !== 3'b101) begin
            errors++;
            $display("FAIL to_set_wins: got %b want 101",
                     {bt.done1, bt.done0, bt.timeout_err});
        end
        bt.err_clr = 1'b1;
        @(negedge clk);
        bt.err_clr = 1'b0;
    endtask

    task automatic test_corner;
        bit ok;
        int k = 0;
        logic [16:0] e;
        issue_bt(1'b0, 16'h0A0A, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bt.i2c_data !== e[15:0]) begin
            errors++;
            $display("FAIL cc_issue: got exec %b data %h want 1 %h",
                     ok, bt.i2c_data, e[15:0]);
        end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 7) bt.i2c_done = 1'b1;
            if (j == 8) bt.i2c_done = 1'b0;
        end
        checks++;
        if ({bt.done0, bt.timeout_err} !== 2'b10) begin
            errors++;
            $display("FAIL cc_done_at_expiry: got %b want 10",
                     {bt.done0, bt.timeout_err});
        end
        @(negedge clk);
        bt.i2c_done = 1'b1;
        @(negedge clk);
        bt.i2c_done = 1'b0;
        checks++;
        if ({bt.ack0, bt.ack1, bt.done0, bt.done1, bt.i2c_exec,
             bt.busy, bt.timeout_err} !== 7'd0) begin
            errors++;
            $display("FAIL cc_spurious_idle: got %b want 0",
                     {bt.ack0, bt.ack1, bt.done0, bt.done1, bt.i2c_exec,
                      bt.busy, bt.timeout_err});
        end
        bt.data0 = 16'h0B0B;
        bt.req0  = 1'b1;
        @(negedge clk);
        bt.req0     = 1'b0;
        bt.i2c_done = 1'b1;
        @(negedge clk);
        bt.i2c_done = 1'b0;
        checks++;
        if ({bt.i2c_exec, bt.done0} !== 2'b10) begin
            errors++;
            $display("FAIL cc_spurious_issue: got %b want 10",
                     {bt.i2c_exec, bt.done0});
        end
        while (!bt.done0 && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (k !== 8 || bt.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL cc_issue_timeout: got %0d err %b want 8 err 1",
                     k, bt.timeout_err);
        end
        bt.err_clr = 1'b1;
        @(negedge clk);
        bt.err_clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit stray = 0;
        logic [16:0] e;
        issue_bt(1'b1, 16'h3333, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bt.i2c_data !== e[15:0]) begin
            errors++;
            $display("FAIL rm_issue: got exec %b data %h want 1 %h",
                     ok, bt.i2c_data, e[15:0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bt.ack0, bt.ack1, bt.done0, bt.done1, bt.i2c_exec,
             bt.i2c_data, bt.busy, bt.timeout_err} !== 23'd0) begin
            errors++;
            $display("FAIL rm_outputs: got data %h busy %b want 0",
                     bt.i2c_data, bt.busy);
        end
        repeat (12) begin
            @(negedge clk);
            stray = stray | bt.done0 | bt.done1 | bt.timeout_err;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL rm_no_done: got %b want 0", stray);
        end
        issue_bt(1'b0, 16'h0E0F, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bt.i2c_data !== e[15:0]) begin
            errors++;
            $display("FAIL rm_after: got exec %b data %h want 1 %h",
                     ok, bt.i2c_data, e[15:0]);
        end
        @(negedge clk);
        bt.i2c_done = 1'b1;
        @(negedge clk);
        bt.i2c_done = 1'b0;
        checks++;
        if ({bt.done0, bt.done1, bt.timeout_err, bt.busy} !== 4'b1000) begin
            errors++;
            $display("FAIL rm_after_done: got %b want 1000",
                     {bt.done0, bt.done1, bt.timeout_err, bt.busy});
        end
    endtask

    initial begin
        rst = 1'b1;
        bf.req0 = 1'b0; bf.req1 = 1'b0; bf.data0 = '0; bf.data1 = '0;
        bf.err_clr = 1'b0;
        br.req0 = 1'b0; br.req1 = 1'b0; br.data0 = '0; br.data1 = '0;
        br.err_clr = 1'b0;
        bt.req0 = 1'b0; bt.req1 = 1'b0; bt.data0 = '0; bt.data1 = '0;
        bt.err_clr = 1'b0; bt.i2c_done = 1'b0;
        test_reset();
        test_single();
        test_fixed_prio();
        test_round_robin();
        test_timeout();
        test_corner();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
